// File: rtl/coord_mem_responder_pkg.sv
// rtl/coord_mem_responder_pkg.sv - shared types and helpers for the coordinate memory responder
package CoordMemPkg;

  typedef enum logic {
    STATE_CLEAR = 1'b0,
    STATE_READY = 1'b1
  } state_t;

  // Index width for an n-entry array; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/coord_rsp_fifo.sv
// rtl/coord_rsp_fifo.sv - in-order response buffer; head word reads as zero when empty
module coord_rsp_fifo
  import CoordMemPkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = idx_bits(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [2**PW];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= (wptr == LAST) ? '0 : wptr + PW'(1);
      if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) slots[wptr] <= push_data;
  end

  assign head = (count != '0) ? slots[rptr] : '0;

endmodule

// File: rtl/coord_mem_responder.sv
// rtl/coord_mem_responder.sv - coordinate read responder: cleared word array, in-order read
// data channel with occupancy-based flow control, and a host write port.
module coord_mem_responder
  import CoordMemPkg::*;
#(
  parameter int CADDR_BITS = 16,
  parameter int CDATA_BITS = 16,
  parameter int DEPTH      = 1024,
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  crvalid,
  input  logic [CADDR_BITS-1:0] craddr,
  output logic                  crready,
  output logic                  cvalid,
  output logic [CDATA_BITS-1:0] cdata,
  input  logic                  cready,
  input  logic                  wvalid,
  input  logic [CADDR_BITS-1:0] waddr,
  input  logic [CDATA_BITS-1:0] wdata,
  output logic                  wready,
  output logic                  init_done,
  output logic                  oor_err
);

  localparam int IDX_W = idx_bits(DEPTH);
  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CADDR_BITS:0] DEPTH_LIM = (CADDR_BITS + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0]    OCC_MAX   = OCC_W'(RSP_DEPTH);

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0]      ctr;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      fifo_count;
  logic                  clear_en;
  logic [CDATA_BITS-1:0] mem [DEPTH];
  logic [CDATA_BITS-1:0] mem_q;
  logic                  rd_inflight;
  logic                  rd_oor_q;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  pop;
  logic                  rd_oor;
  logic                  wr_oor;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [CDATA_BITS-1:0] push_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= STATE_CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_en  = 1'b0;
    crready   = 1'b0;
    wready    = 1'b0;
    init_done = 1'b0;
    case (state)
      STATE_CLEAR: begin
        clear_en = 1'b1;
        if (ctr == LAST_IDX) state_nxt = STATE_READY;
      end
      STATE_READY: begin
        wready    = 1'b1;
        init_done = 1'b1;
        crready   = (occ < OCC_MAX);
      end
    endcase
  end

  assign rd_fire = crvalid && crready;
  assign wr_fire = wvalid && wready;
  assign pop     = cvalid && cready;
  assign rd_oor  = ({1'b0, craddr} >= DEPTH_LIM);
  assign wr_oor  = ({1'b0, waddr} >= DEPTH_LIM);
  assign rd_idx  = craddr[IDX_W-1:0];
  assign wr_idx  = waddr[IDX_W-1:0];

  // occ covers reads still in the array pipeline, so the FIFO can never overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctr         <= '0;
      occ         <= '0;
      oor_err     <= 1'b0;
      rd_inflight <= 1'b0;
      rd_oor_q    <= 1'b0;
    end else begin
      if (clear_en) ctr <= (ctr == LAST_IDX) ? '0 : ctr + IDX_W'(1);
      rd_inflight <= rd_fire;
      rd_oor_q    <= rd_fire && rd_oor;
      if (rd_fire && !pop)      occ <= occ + OCC_W'(1);
      else if (!rd_fire && pop) occ <= occ - OCC_W'(1);
      if ((rd_fire && rd_oor) || (wr_fire && wr_oor)) oor_err <= 1'b1;
    end
  end

  // Same-cycle read and write of one word: the read captures the pre-write contents.
  always_ff @(posedge clock) begin
    if (clear_en)               mem[ctr]    <= '0;
    else if (wr_fire && !wr_oor) mem[wr_idx] <= wdata;
    if (rd_fire && !rd_oor) mem_q <= mem[rd_idx];
  end

  assign push_data = rd_oor_q ? '0 : mem_q;

  coord_rsp_fifo #(
    .WIDTH (CDATA_BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (cdata),
    .count     (fifo_count)
  );

  assign cvalid = (fifo_count != '0);

endmodule
